// File: rtl/regfile_bypass_sb_pkg.sv
// Shared defaults, zero-register constant and port slicing helpers for the register file.
`ifndef REGFILE_BYPASS_SB_PKG_SV
`define REGFILE_BYPASS_SB_PKG_SV

// Port slice of a flattened multi-port bus: bus[idx*width +: width].
`define RF_PORT(bus, idx, width) bus[(idx)*(width) +: (width)]

package regfile_bypass_sb_pkg;

  localparam int unsigned RF_DW_DEF = 32;
  localparam int unsigned RF_AW_DEF = 5;
  localparam int unsigned RF_NR_DEF = 3;
  localparam int unsigned RF_NW_DEF = 2;

  // Register hardwired to zero: never written, bypassed or busy.
  localparam int unsigned RF_ZERO = 0;

endpackage

`endif

// File: rtl/regfile_sb_popcount.sv
// Combinational population count of the scoreboard busy vector.
module regfile_sb_popcount #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 6
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt_c
);

  // Sum of set bits.
  always_comb begin
    cnt_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cnt_c = cnt_c + W'(vec[k]);
    end
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with write-first bypass and per-register busy scoreboard.
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int unsigned DW = RF_DW_DEF,
  parameter int unsigned AW = RF_AW_DEF,
  parameter int unsigned NR = RF_NR_DEF,
  parameter int unsigned NW = RF_NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rbusy,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*DW-1:0] wd,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  input  logic             flush,
  output logic [AW:0]      busy_cnt
);

  localparam int unsigned DEPTH = 32'(1) << AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] wr_hit_c;
  logic [CW-1:0]    cnt_nxt_c;

  // Decode which registers are targeted by any enabled write port this cycle.
  always_comb begin
    wr_hit_c = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      if (we[j]) begin
        wr_hit_c[`RF_PORT(wa, j, AW)] = 1'b1;
      end
    end
    wr_hit_c[RF_ZERO] = 1'b0;
  end

  // Array write; ascending port order lets the highest index win on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NW; j++) begin
        if (we[j] && (`RF_PORT(wa, j, AW) != AW'(RF_ZERO))) begin
          mem[`RF_PORT(wa, j, AW)] <= `RF_PORT(wd, j, DW);
        end
      end
    end
  end

  // Scoreboard next state: flush beats issue, issue beats writeback clear.
  always_comb begin
    busy_nxt = busy & ~wr_hit_c;
    if (issue_en) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[RF_ZERO] = 1'b0;
  end

  regfile_sb_popcount #(
    .N (DEPTH),
    .W (CW)
  ) u_popcount (
    .vec   (busy_nxt),
    .cnt_c (cnt_nxt_c)
  );

  // Scoreboard and its count update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt_c;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] addr_c;
    logic [DW-1:0] data_c;
    logic          hit_c;

    assign addr_c = `RF_PORT(ra, i, AW);

    // Write-first bypass from the highest-index matching write port.
    always_comb begin
      data_c = mem[addr_c];
      hit_c  = 1'b0;
      for (int unsigned j = 0; j < NW; j++) begin
        if (we[j] && (`RF_PORT(wa, j, AW) == addr_c)) begin
          data_c = `RF_PORT(wd, j, DW);
          hit_c  = 1'b1;
        end
      end
      if (addr_c == AW'(RF_ZERO)) begin
        data_c = '0;
        hit_c  = 1'b0;
      end
    end

    assign `RF_PORT(rd, i, DW) = data_c;
    assign rbusy[i] = busy[addr_c] & ~hit_c;
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Testbench: directed table on the default configuration, randomized model check on a small one.
module tb_regfile_bypass_sb;

  logic clk;
  logic rst;

  // Default configuration: DW=32 AW=5 NR=3 NW=2
  logic [14:0] d_ra;
  logic [95:0] d_rd;
  logic [2:0]  d_rbusy;
  logic [1:0]  d_we;
  logic [9:0]  d_wa;
  logic [63:0] d_wd;
  logic        d_issue_en;
  logic [4:0]  d_issue_addr;
  logic        d_flush;
  logic [5:0]  d_busy_cnt;

  // Sweep configuration: DW=16 AW=3 NR=4 NW=3
  logic [11:0] p_ra;
  logic [63:0] p_rd;
  logic [3:0]  p_rbusy;
  logic [2:0]  p_we;
  logic [8:0]  p_wa;
  logic [47:0] p_wd;
  logic        p_issue_en;
  logic [2:0]  p_issue_addr;
  logic        p_flush;
  logic [3:0]  p_busy_cnt;

  int tests;
  int failed;

  regfile_bypass_sb #(.DW(32), .AW(5), .NR(3), .NW(2)) u_dut (
    .clk(clk), .rst(rst), .ra(d_ra), .rd(d_rd), .rbusy(d_rbusy),
    .we(d_we), .wa(d_wa), .wd(d_wd), .issue_en(d_issue_en),
    .issue_addr(d_issue_addr), .flush(d_flush), .busy_cnt(d_busy_cnt)
  );

  regfile_bypass_sb #(.DW(16), .AW(3), .NR(4), .NW(3)) u_sweep (
    .clk(clk), .rst(rst), .ra(p_ra), .rd(p_rd), .rbusy(p_rbusy),
    .we(p_we), .wa(p_wa), .wd(p_wd), .issue_en(p_issue_en),
    .issue_addr(p_issue_addr), .flush(p_flush), .busy_cnt(p_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] e_rd0, e_rd1;
    logic        e_rb0, e_rb1;
    logic [5:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
    input logic [31:0] wd0, input logic [31:0] wd1,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic iss, input logic [4:0] ia, input logic fl,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1,
    input logic e_rb0, input logic e_rb1, input logic [5:0] e_cnt);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ia = ia; v.fl = fl;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb0 = e_rb0; v.e_rb1 = e_rb1; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive_d(input vec_t v);
    d_we         = v.we;
    d_wa         = {v.wa1, v.wa0};
    d_wd         = {v.wd1, v.wd0};
    d_ra         = {5'd0, v.ra1, v.ra0};
    d_issue_en   = v.iss;
    d_issue_addr = v.ia;
    d_flush      = v.fl;
  endtask

  function automatic vec_t idle(input logic [4:0] ra0, input logic [4:0] ra1);
    return mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, ra0, ra1, 1'b0, 5'd0, 1'b0,
              32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
  endfunction

  // Reference model state for the sweep configuration
  logic [15:0] m_mem [8];
  bit          m_busy [8];

  vec_t tbl [16];

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    drive_d(idle(5'd0, 5'd0));
    p_ra = '0; p_we = '0; p_wa = '0; p_wd = '0;
    p_issue_en = 1'b0; p_issue_addr = '0; p_flush = 1'b0;
    for (int r = 0; r < 8; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 1'b0;
    end

    // ---- Reset sequence ----
    @(negedge clk); #1;
    chk("reset rd0", 64'(d_rd[31:0]), 64'h0);
    chk("reset busy_cnt", 64'(d_busy_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_d(mk(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 1'b1, 5'd6, 1'b0,
               0, 0, 0, 0, 0));
    @(negedge clk);
    drive_d(idle(5'd5, 5'd6)); #1;
    chk("pre-reset rd0", 64'(d_rd[31:0]), 64'hDEADBEEF);
    chk("pre-reset busy_cnt", 64'(d_busy_cnt), 64'd1);
    chk("pre-reset rbusy1", 64'(d_rbusy[1]), 64'd1);
    @(negedge clk);
    // Reset asserted with a write and an issue pending; both must be discarded
    drive_d(mk(2'b01, 5'd12, 5'd0, 32'h1234, 32'h0, 5'd5, 5'd12, 1'b1, 5'd13, 1'b0,
               0, 0, 0, 0, 0));
    rst = 1'b1; #1;
    chk("async reset busy_cnt", 64'(d_busy_cnt), 64'd0);
    chk("async reset rd0 r5", 64'(d_rd[31:0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_d(idle(5'd5, 5'd12)); #1;
    chk("post-reset rd0 r5", 64'(d_rd[31:0]), 64'h0);
    chk("post-reset rd1 r12", 64'(d_rd[63:32]), 64'h0);
    chk("post-reset busy_cnt", 64'(d_busy_cnt), 64'd0);

    // ---- Directed table: rows applied on consecutive cycles ----
    //            we     wa0    wa1    wd0           wd1       ra0    ra1    iss  ia     fl    rd0       rd1       rb0  rb1  cnt
    tbl[0]  = mk(2'b11, 5'd7,  5'd7,  32'h11,       32'h22,   5'd7,  5'd0,  0,   5'd0,  0,    32'h22,   32'h0,    0,   0,   6'd0);
    tbl[1]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd7,  5'd7,  0,   5'd0,  0,    32'h22,   32'h22,   0,   0,   6'd0);
    tbl[2]  = mk(2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,    5'd0,  5'd7,  1,   5'd0,  0,    32'h0,    32'h22,   0,   0,   6'd0);
    tbl[3]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd7,  0,   5'd0,  0,    32'h0,    32'h22,   0,   0,   6'd0);
    tbl[4]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd3,  1,   5'd3,  0,    32'h0,    32'h0,    0,   0,   6'd0);
    tbl[5]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd3,  0,   5'd0,  0,    32'h0,    32'h0,    0,   1,   6'd1);
    tbl[6]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd3,  0,   5'd0,  0,    32'h0,    32'h0,    0,   1,   6'd1);
    tbl[7]  = mk(2'b01, 5'd3,  5'd0,  32'h55,       32'h0,    5'd7,  5'd3,  0,   5'd0,  0,    32'h22,   32'h55,   0,   0,   6'd1);
    tbl[8]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd7,  5'd3,  0,   5'd0,  0,    32'h22,   32'h55,   0,   0,   6'd0);
    tbl[9]  = mk(2'b10, 5'd0,  5'd9,  32'h0,        32'h99,   5'd9,  5'd3,  1,   5'd9,  0,    32'h99,   32'h55,   0,   0,   6'd0);
    tbl[10] = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd9,  5'd3,  0,   5'd0,  0,    32'h99,   32'h55,   1,   0,   6'd1);
    tbl[11] = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd4,  5'd9,  1,   5'd4,  0,    32'h0,    32'h99,   0,   1,   6'd1);
    tbl[12] = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd4,  5'd9,  1,   5'd4,  1,    32'h0,    32'h99,   1,   1,   6'd2);
    tbl[13] = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd4,  5'd9,  0,   5'd0,  0,    32'h0,    32'h99,   0,   0,   6'd0);
    tbl[14] = mk(2'b11, 5'd10, 5'd11, 32'hA0,       32'hB1,   5'd10, 5'd11, 0,   5'd0,  0,    32'hA0,   32'hB1,   0,   0,   6'd0);
    tbl[15] = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd10, 5'd11, 0,   5'd0,  0,    32'hA0,   32'hB1,   0,   0,   6'd0);

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive_d(tbl[k]); #1;
      chk($sformatf("row%0d rd0", k), 64'(d_rd[31:0]), 64'(tbl[k].e_rd0));
      chk($sformatf("row%0d rd1", k), 64'(d_rd[63:32]), 64'(tbl[k].e_rd1));
      chk($sformatf("row%0d rbusy0", k), 64'(d_rbusy[0]), 64'(tbl[k].e_rb0));
      chk($sformatf("row%0d rbusy1", k), 64'(d_rbusy[1]), 64'(tbl[k].e_rb1));
      chk($sformatf("row%0d busy_cnt", k), 64'(d_busy_cnt), 64'(tbl[k].e_cnt));
    end
    @(negedge clk);
    drive_d(idle(5'd0, 5'd0));

    // ---- Randomized sweep against the reference model ----
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic        do_rst;
      logic [15:0] exp_rd;
      logic        hit;
      logic [2:0]  a;
      logic [2:0]  waj;
      bit          whit [8];
      int          cnt;

      @(negedge clk);
      do_rst       = ($urandom_range(0, 299) == 0);
      p_we         = 3'($urandom);
      p_wa         = 9'($urandom);
      p_wd         = {16'($urandom), 16'($urandom), 16'($urandom)};
      p_ra         = 12'($urandom);
      p_issue_en   = ($urandom_range(0, 1) == 1);
      p_issue_addr = 3'($urandom);
      p_flush      = ($urandom_range(0, 24) == 0);
      rst          = do_rst;
      #1;

      if (do_rst) begin
        for (int r = 0; r < 8; r++) begin
          m_mem[r] = '0;
          m_busy[r] = 1'b0;
        end
      end

      for (int i = 0; i < 4; i++) begin
        a = p_ra[i*3 +: 3];
        exp_rd = m_mem[a];
        hit = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (p_we[j] && p_wa[j*3 +: 3] == a) begin
            exp_rd = p_wd[j*16 +: 16];
            hit = 1'b1;
          end
        end
        if (a == 3'd0) exp_rd = '0;
        chk($sformatf("cyc%0d rd%0d", cyc, i), 64'(p_rd[i*16 +: 16]), 64'(exp_rd));
        chk($sformatf("cyc%0d rbusy%0d", cyc, i), 64'(p_rbusy[i]),
            64'((a != 3'd0) && m_busy[a] && !hit));
      end
      cnt = 0;
      for (int r = 0; r < 8; r++) cnt += int'(m_busy[r]);
      chk($sformatf("cyc%0d busy_cnt", cyc), 64'(p_busy_cnt), 64'(cnt));

      if (!do_rst) begin
        for (int r = 0; r < 8; r++) whit[r] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          waj = p_wa[j*3 +: 3];
          if (p_we[j]) begin
            whit[waj] = 1'b1;
            if (waj != 3'd0) m_mem[waj] = p_wd[j*16 +: 16];
          end
        end
        for (int r = 1; r < 8; r++) begin
          if (p_flush) m_busy[r] = 1'b0;
          else if (p_issue_en && p_issue_addr == 3'(r)) m_busy[r] = 1'b1;
          else if (whit[r]) m_busy[r] = 1'b0;
        end
      end
    end

    @(negedge clk);
    rst = 1'b0;
    p_we = '0; p_issue_en = 1'b0; p_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
